chain_cost_eval: RTL and testbench
==================================

Name: chain_cost_eval

Overview:
- Downstream consumer of the chain-order index generator in the matrix-chain multiplier.
- Accepts one (i, j, k) split candidate per cycle and fetches p[i], p[k+1], p[j+1] from the dimension store, and m[i][k], m[k+1][j] from the cost table.
- Forms the candidate cost, tracks the minimum over all k of the current (i, j) group, and on the group's last candidate writes m[i][j] and the winning split s[i][j].
- Matrix A_x is p[x] by p[x+1]; indices are 0-based.

Parameters:
- IDX_W, 8, width of i/j/k and matlen
- DIM_W, 8, width of one dimension value p[x]
- COST_W, 32, width of a cost-table entry; must be at least DIM_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- matlen  in  IDX_W  number of matrices in the chain; held stable during a run
- idx_valid  in  1  upstream candidate valid
- idx_ready  out  1  block can accept a candidate
- idx_i, idx_j, idx_k  in  IDX_W each  candidate indices, i <= k < j
- idx_last  in  1  final k of the current (i, j) group
- dim_addr0, dim_addr1, dim_addr2  out  IDX_W each  dimension addresses i, k+1, j+1
- dim_data0, dim_data1, dim_data2  in  DIM_W each  sync-read data, one-cycle latency
- cost_ra_addr, cost_rb_addr  out  2*IDX_W each  {row,col} addresses of m[i][k] and m[k+1][j]
- cost_ra_data, cost_rb_data  in  COST_W each  sync-read data, one-cycle latency
- cost_we  out  1  write strobe for the cost and split tables
- cost_waddr  out  2*IDX_W  {i,j}
- cost_wdata  out  COST_W  minimum cost
- split_wdata  out  IDX_W  winning k
- done  out  1  one-cycle pulse on the write of m[0][matlen-1]

Behaviour:
- Reset values: idx_ready=1; cost_we=0; done=0; all addresses and write data 0; running min = all ones; all stage valids 0.
- Handshake: a candidate transfers on any cycle T with idx_valid && idx_ready.
- Pipeline: 3 stages, accept cycle T.
  - T+1 (stage A): indices registered; address ports are driven from stage A.
  - T+2 (stage B): read data valid. Candidate = p[i]*p[k+1]*p[j+1] + ma + mb, where ma = 0 if i==k and mb = 0 if k+1==j. Diagonal entries are masked, not read from memory. Result is registered.
  - T+3 (stage C): candidate compared with the running min. Update only on strict less-than, so ties keep the earlier k.
- Write: if the stage C entry carries last, then in T+3:
  - cost_we=1, cost_waddr={i,j}, cost_wdata=min(running, candidate), split_wdata=winning k.
  - Running min returns to all ones at the end of T+3.
- Group start: the first accept after reset or after a last starts a new group. Its candidate compares against all ones.
- Arithmetic: the product is 3*DIM_W bits, unsigned. The sum is computed at full width, then saturated to COST_W all ones if it overflows.
- Drain (read-after-write hazard): after accepting a last in T, idx_ready is 0 during T+1..T+3 and returns to 1 in T+4. The next diagonal's reads therefore always see the completed write.
- Within a group, throughput is 1 candidate per cycle.
- done: asserted with cost_we when i==0 and j==matlen-1. If matlen<2, no candidates arrive and done never asserts.
- Reset mid-operation: all stage valids are cleared and any in-flight write is suppressed (cost_we=0 on the cycle after rst). The running min returns to all ones.
- Protocol errors: idx_valid with k outside [i, j-1] is a protocol violation. Outputs are undefined but must not lock up.

Decomposition:
- Shared package chain_pkg holds:
  - IDX_W, DIM_W, COST_W defaults
  - COST_MAX (all ones)
  - a pack function for the {row,col} address
  - a candidate-record typedef (i, j, k, last)
- Sub-module chain_cost_calc holds the stage B arithmetic: 3-way product, diagonal masking, saturating add. It is purely combinational, registered by the parent.

Test Plan:
- p={10,20,30}, matlen=2, candidate (0,1,0,last) -> cost_we in T+3, waddr {0,1}, wdata 6000, split 0, done=1.
- p={10,30,5,60}, m[0][1]=1500, m[1][2]=9000, group (0,2) with k=0 then k=1(last) -> wdata 4500, split 1, done=1.
- Tie: candidates with k=0 and k=1 both costing 500 -> split 0.
- COST_W=20, all p=255, diagonal group -> 16581375 overflows, wdata saturates to 1048575.
- idx_valid held high across a last -> idx_ready low exactly 3 cycles. The next candidate is accepted in T+4 and its read returns the just-written value.
- rst asserted in T+2 of a last candidate -> no cost_we, no done. The next group's first candidate is compared against all ones.

Source files
------------

// File: rtl/chain_pkg.sv
// Shared definitions for the matrix-chain cost evaluator.
//   IDX_W/DIM_W/COST_W : default widths of indices, dimensions and costs
//   COST_MAX           : all-ones cost at the default width
//   cand_t             : one (i, j, k, last) split candidate
//   pack_rc            : forms a {row,col} table address
package chain_pkg;

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned COST_W = 32;

  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] k;
    logic             last;
  } cand_t;

  function automatic logic [2*IDX_W-1:0] pack_rc(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/chain_cost_calc.sv
// Combinational candidate cost: p0*p1*p2 + ma + mb, saturated to COST_W.
//   p0, p1, p2     : dimensions p[i], p[k+1], p[j+1]
//   ma, mb         : m[i][k] and m[k+1][j] as read from the cost table
//   mask_a, mask_b : treat ma / mb as zero (diagonal entries)
//   cost           : saturated candidate cost
module chain_cost_calc #(
  parameter int unsigned DIM_W  = chain_pkg::DIM_W,
  parameter int unsigned COST_W = chain_pkg::COST_W
) (
  input  logic [DIM_W-1:0]  p0,
  input  logic [DIM_W-1:0]  p1,
  input  logic [DIM_W-1:0]  p2,
  input  logic [COST_W-1:0] ma,
  input  logic [COST_W-1:0] mb,
  input  logic              mask_a,
  input  logic              mask_b,
  output logic [COST_W-1:0] cost
);

  localparam int unsigned PW = 3 * DIM_W;
  // Two guard bits cover the carries of a three-term sum.
  localparam int unsigned SW = ((PW > COST_W) ? PW : COST_W) + 2;

  logic [PW-1:0] prod;
  logic [SW-1:0] sum;

  always_comb begin
    prod = PW'(p0) * PW'(p1) * PW'(p2);
    sum  = SW'(prod) + SW'(mask_a ? '0 : ma) + SW'(mask_b ? '0 : mb);
    cost = (|sum[SW-1:COST_W]) ? '1 : sum[COST_W-1:0];
  end

endmodule

// File: rtl/chain_cost_eval.sv
// Matrix-chain cost evaluator: takes one (i, j, k) split candidate per cycle,
// reads p[i], p[k+1], p[j+1], m[i][k], m[k+1][j], keeps the minimum over the
// (i, j) group and writes m[i][j] / s[i][j] on the group's last candidate.
//   clk, rst                 : clock, synchronous active-high reset
//   matlen                   : chain length, stable during a run
//   idx_valid/idx_ready      : candidate handshake; idx_i/j/k, idx_last
//   dim_addr0..2/dim_data0..2: dimension store, one-cycle read latency
//   cost_ra/rb_addr/_data    : cost table read ports, one-cycle latency
//   cost_we, cost_waddr, cost_wdata, split_wdata : table write port
//   done                     : pulse on the write of m[0][matlen-1]
// IDX_W must stay at the package default (cand_t and pack_rc use it).
module chain_cost_eval #(
  parameter int unsigned IDX_W  = chain_pkg::IDX_W,
  parameter int unsigned DIM_W  = chain_pkg::DIM_W,
  parameter int unsigned COST_W = chain_pkg::COST_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    matlen,
  input  logic                idx_valid,
  output logic                idx_ready,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [IDX_W-1:0]    idx_j,
  input  logic [IDX_W-1:0]    idx_k,
  input  logic                idx_last,
  output logic [IDX_W-1:0]    dim_addr0,
  output logic [IDX_W-1:0]    dim_addr1,
  output logic [IDX_W-1:0]    dim_addr2,
  input  logic [DIM_W-1:0]    dim_data0,
  input  logic [DIM_W-1:0]    dim_data1,
  input  logic [DIM_W-1:0]    dim_data2,
  output logic [2*IDX_W-1:0]  cost_ra_addr,
  output logic [2*IDX_W-1:0]  cost_rb_addr,
  input  logic [COST_W-1:0]   cost_ra_data,
  input  logic [COST_W-1:0]   cost_rb_data,
  output logic                cost_we,
  output logic [2*IDX_W-1:0]  cost_waddr,
  output logic [COST_W-1:0]   cost_wdata,
  output logic [IDX_W-1:0]    split_wdata,
  output logic                done
);

  import chain_pkg::*;

  logic [1:0]        drain_q;
  logic              sa_vld, sb_vld, sc_vld;
  cand_t             sa_q, sb_q, sc_q;
  logic [COST_W-1:0] cand_cost, sc_cost, min_q;
  logic [IDX_W-1:0]  mink_q;
  logic              grp_open;
  logic              accept, take;

  assign idx_ready = (drain_q == '0);
  assign accept    = idx_valid && idx_ready;

  chain_cost_calc #(
    .DIM_W (DIM_W),
    .COST_W(COST_W)
  ) u_calc (
    .p0    (dim_data0),
    .p1    (dim_data1),
    .p2    (dim_data2),
    .ma    (cost_ra_data),
    .mb    (cost_rb_data),
    .mask_a(sb_q.i == sb_q.k),
    .mask_b((sb_q.k + IDX_W'(1)) == sb_q.j),
    .cost  (cand_cost)
  );

  // The first candidate of a group always wins, so a saturated first cost
  // still reports that group's first k; afterwards only strictly smaller
  // costs replace the minimum, keeping the earliest k on ties.
  always_comb begin
    take        = sc_vld && (!grp_open || (sc_cost < min_q));
    cost_we     = sc_vld && sc_q.last;
    cost_waddr  = '0;
    cost_wdata  = '0;
    split_wdata = '0;
    if (cost_we) begin
      cost_waddr  = pack_rc(sc_q.i, sc_q.j);
      cost_wdata  = take ? sc_cost : min_q;
      split_wdata = take ? sc_q.k : mink_q;
    end
    done = cost_we && (sc_q.i == '0) && (sc_q.j == (matlen - IDX_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q      <= '0;
      sa_vld       <= 1'b0;
      sb_vld       <= 1'b0;
      sc_vld       <= 1'b0;
      sa_q         <= '0;
      sb_q         <= '0;
      sc_q         <= '0;
      sc_cost      <= '0;
      min_q        <= '1;
      mink_q       <= '0;
      grp_open     <= 1'b0;
      dim_addr0    <= '0;
      dim_addr1    <= '0;
      dim_addr2    <= '0;
      cost_ra_addr <= '0;
      cost_rb_addr <= '0;
    end else begin
      // Stage A: capture the candidate and present the read addresses.
      sa_vld <= accept;
      if (accept) begin
        sa_q.i       <= idx_i;
        sa_q.j       <= idx_j;
        sa_q.k       <= idx_k;
        sa_q.last    <= idx_last;
        dim_addr0    <= idx_i;
        dim_addr1    <= idx_k + IDX_W'(1);
        dim_addr2    <= idx_j + IDX_W'(1);
        cost_ra_addr <= pack_rc(idx_i, idx_k);
        cost_rb_addr <= pack_rc(idx_k + IDX_W'(1), idx_j);
      end

      // Hold off three cycles after a last so the next group's reads see
      // the m[i][j] write that happens in the last's stage C.
      if (accept && idx_last) drain_q <= 2'd3;
      else if (drain_q != '0) drain_q <= drain_q - 2'd1;

      // Stage B: read data arrives; register the candidate cost.
      sb_vld <= sa_vld;
      if (sa_vld) sb_q <= sa_q;

      sc_vld <= sb_vld;
      if (sb_vld) begin
        sc_q    <= sb_q;
        sc_cost <= cand_cost;
      end

      // Stage C: running minimum, cleared once the group is written.
      if (sc_vld) begin
        if (sc_q.last) begin
          min_q    <= '1;
          grp_open <= 1'b0;
        end else if (take) begin
          min_q    <= sc_cost;
          mink_q   <= sc_q.k;
          grp_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chain_cost_eval.sv
module tb_chain_cost_eval;

  localparam int    CW   = 20;
  localparam longint CMAX = (longint'(1) << CW) - 1;
  localparam logic [CW-1:0] JUNK = 20'h5A5A5;

  logic           clk, rst;
  logic [7:0]     matlen;
  logic           idx_valid, idx_ready, idx_last;
  logic [7:0]     idx_i, idx_j, idx_k;
  logic [7:0]     dim_addr0, dim_addr1, dim_addr2;
  logic [7:0]     dim_data0, dim_data1, dim_data2;
  logic [15:0]    cost_ra_addr, cost_rb_addr, cost_waddr;
  logic [CW-1:0]  cost_ra_data, cost_rb_data, cost_wdata;
  logic           cost_we, done;
  logic [7:0]     split_wdata;

  chain_cost_eval #(.COST_W(CW)) dut (
    .clk(clk), .rst(rst), .matlen(matlen),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k), .idx_last(idx_last),
    .dim_addr0(dim_addr0), .dim_addr1(dim_addr1), .dim_addr2(dim_addr2),
    .dim_data0(dim_data0), .dim_data1(dim_data1), .dim_data2(dim_data2),
    .cost_ra_addr(cost_ra_addr), .cost_rb_addr(cost_rb_addr),
    .cost_ra_data(cost_ra_data), .cost_rb_data(cost_rb_data),
    .cost_we(cost_we), .cost_waddr(cost_waddr), .cost_wdata(cost_wdata),
    .split_wdata(split_wdata), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Dimension store and cost table, both one-cycle synchronous read.
  logic [7:0]    dmem [0:31];
  logic [CW-1:0] cmem [0:15][0:15];
  logic          pl_we = 1'b0, pl_clr = 1'b0;
  logic [3:0]    pl_r, pl_c;
  logic [CW-1:0] pl_v;

  always @(posedge clk) begin
    dim_data0    <= dmem[dim_addr0[4:0]];
    dim_data1    <= dmem[dim_addr1[4:0]];
    dim_data2    <= dmem[dim_addr2[4:0]];
    cost_ra_data <= cmem[cost_ra_addr[11:8]][cost_ra_addr[3:0]];
    cost_rb_data <= cmem[cost_rb_addr[11:8]][cost_rb_addr[3:0]];
    if (pl_clr) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) cmem[r][c] <= JUNK;
    end else if (pl_we) cmem[pl_r][pl_c] <= pl_v;
    else if (cost_we) cmem[cost_waddr[11:8]][cost_waddr[3:0]] <= cost_wdata;
  end

  // Write monitor.
  int wq_addr[$], wq_data[$], wq_split[$], wq_cyc[$];
  bit wq_done[$];
  int stray_done = 0;
  always @(negedge clk) begin
    if (cost_we) begin
      wq_addr.push_back(int'(cost_waddr));
      wq_data.push_back(int'(cost_wdata));
      wq_split.push_back(int'(split_wdata));
      wq_done.push_back(done);
      wq_cyc.push_back(cyc);
    end else if (done) stray_done++;
  end

  // Reference model: the cost recurrence over the bench's own tables.
  int     pp [0:31];
  longint mm [0:15][0:15];

  function automatic longint mcost(input int i, input int k, input int j);
    longint c;
    c = longint'(pp[i]) * pp[k+1] * pp[j+1];
    if (i != k)     c += mm[i][k];
    if (k + 1 != j) c += mm[k+1][j];
    return (c > CMAX) ? CMAX : c;
  endfunction

  function automatic void mgroup(input int i, input int j, input int klo, input int khi,
                                 output int bc, output int bk);
    longint best;
    best = 0; bk = -1;
    for (int k = klo; k <= khi; k++) begin
      longint c = mcost(i, k, j);
      if (bk < 0 || c < best) begin best = c; bk = k; end
    end
    bc = int'(best);
  endfunction

  task automatic set_dim(input int x, input int v);
    dmem[x] = 8'(v);
    pp[x]   = v;
  endtask

  task automatic set_matlen(input int n);
    @(negedge clk);
    matlen = 8'(n);
  endtask

  task automatic clear_tab();
    @(negedge clk); pl_clr = 1'b1;
    @(negedge clk); pl_clr = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mm[r][c] = 0;
  endtask

  task automatic preload(input int r, input int c, input int v);
    @(negedge clk);
    pl_r = 4'(r); pl_c = 4'(c); pl_v = CW'(v); pl_we = 1'b1;
    @(negedge clk); pl_we = 1'b0;
    mm[r][c] = v;
  endtask

  task automatic idle(input int n);
    for (int x = 0; x < n; x++) begin
      @(negedge clk);
      idx_valid = 1'b0;
    end
  endtask

  // Presents a candidate and holds it until accepted; acc is the accept cycle.
  task automatic drive(input int i, input int j, input int k, input bit last,
                       output int acc, output int stalls);
    @(negedge clk);
    idx_i = 8'(i); idx_j = 8'(j); idx_k = 8'(k); idx_last = last; idx_valid = 1'b1;
    stalls = 0; acc = -1;
    while (!idx_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (idx_ready) begin
      acc = cyc;
      @(posedge clk);
    end else begin
      checks++; errors++;
      $display("FAIL drive.ready_timeout: idx_ready=%0b after %0d cycles, required 1", idx_ready, stalls);
      idx_valid = 1'b0;
    end
  endtask

  task automatic wait_write(output bit got, output int a, output int d, output int s,
                            output int c, output bit dn);
    got = 1'b0; a = 0; d = 0; s = 0; c = 0; dn = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      if (wq_addr.size() == 0) begin
        @(negedge clk);
        #1;
      end
      if (wq_addr.size() > 0) begin
        got = 1'b1;
        a = wq_addr.pop_front(); d = wq_data.pop_front(); s = wq_split.pop_front();
        c = wq_cyc.pop_front(); dn = wq_done.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idx_valid = 1'b0; idx_last = 1'b0;
    idx_i = '0; idx_j = '0; idx_k = '0; matlen = '0;
    for (int x = 0; x < 32; x++) set_dim(x, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (idx_ready !== 1'b1) begin errors++; $display("FAIL reset.idx_ready: got %0b expected 1", idx_ready); end
    checks++; if (cost_we !== 1'b0) begin errors++; $display("FAIL reset.cost_we: got %0b expected 0", cost_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done: got %0b expected 0", done); end
    checks++;
    if ({cost_waddr, cost_wdata, split_wdata} !== '0) begin
      errors++; $display("FAIL reset.wport: got %h/%h/%h expected 0", cost_waddr, cost_wdata, split_wdata);
    end
    checks++;
    if ({dim_addr0, dim_addr1, dim_addr2, cost_ra_addr, cost_rb_addr} !== '0) begin
      errors++; $display("FAIL reset.raddr: got %h %h %h %h %h expected 0",
                         dim_addr0, dim_addr1, dim_addr2, cost_ra_addr, cost_rb_addr);
    end
    rst = 1'b0;
  endtask

  // Known groups: single candidate, two-way split, tie, saturation.
  int tp  [4][6] = '{'{10, 20, 30, 1, 1, 1}, '{10, 30, 5, 60, 1, 1},
                     '{1, 100, 100, 1, 1, 1}, '{255, 255, 255, 255, 255, 255}};
  int tm01[4] = '{-1, 1500, 400, -1};
  int tm12[4] = '{-1, 9000, 400, -1};
  int tlen[4] = '{2, 3, 3, 5};
  int tgi [4] = '{0, 0, 0, 2};
  int tgj [4] = '{1, 2, 2, 3};

  task automatic test_groups();
    int acc, st, a, d, s, c, ec, ek;
    bit got, dn;
    for (int t = 0; t < 4; t++) begin
      clear_tab();
      for (int x = 0; x < 6; x++) set_dim(x, tp[t][x]);
      if (tm01[t] >= 0) preload(0, 1, tm01[t]);
      if (tm12[t] >= 0) preload(1, 2, tm12[t]);
      set_matlen(tlen[t]);
      for (int k = tgi[t]; k < tgj[t]; k++) drive(tgi[t], tgj[t], k, k == tgj[t] - 1, acc, st);
      idle(1);
      wait_write(got, a, d, s, c, dn);
      mgroup(tgi[t], tgj[t], tgi[t], tgj[t] - 1, ec, ek);
      checks++; if (!got) begin errors++; $display("FAIL group%0d.write: no cost_we within bound", t); end
      checks++; if (a !== (tgi[t] << 8 | tgj[t])) begin errors++; $display("FAIL group%0d.waddr: got %h expected %h", t, a, tgi[t] << 8 | tgj[t]); end
      checks++; if (d !== ec) begin errors++; $display("FAIL group%0d.wdata: got %0d expected %0d", t, d, ec); end
      checks++; if (s !== ek) begin errors++; $display("FAIL group%0d.split: got %0d expected %0d", t, s, ek); end
      checks++; if (dn !== (tgi[t] == 0 && tgj[t] == tlen[t] - 1)) begin errors++; $display("FAIL group%0d.done: got %0b", t, dn); end
      checks++; if (c !== acc + 3) begin errors++; $display("FAIL group%0d.latency: write cycle %0d expected %0d", t, c, acc + 3); end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, st1, st2, a, d, s, c, ec, ek;
    bit got, dn;
    clear_tab();
    for (int x = 0; x < 4; x++) set_dim(x, 3 + 2 * x);
    preload(0, 1, 777);                 // stale value the second read must not see
    set_matlen(3);
    drive(0, 1, 0, 1'b1, acc1, st1);
    drive(0, 2, 1, 1'b1, acc2, st2);    // idx_valid stays high across the last
    idle(1);
    checks++; if (st2 !== 3) begin errors++; $display("FAIL b2b.stall: idx_ready low %0d cycles, expected 3", st2); end
    checks++; if (acc2 - acc1 !== 4) begin errors++; $display("FAIL b2b.accept: gap %0d expected 4", acc2 - acc1); end
    wait_write(got, a, d, s, c, dn);
    mgroup(0, 1, 0, 0, ec, ek);
    checks++; if (!got || d !== ec) begin errors++; $display("FAIL b2b.first: got %0d expected %0d", d, ec); end
    mm[0][1] = ec;
    wait_write(got, a, d, s, c, dn);
    mgroup(0, 2, 1, 1, ec, ek);
    checks++; if (!got || d !== ec) begin errors++; $display("FAIL b2b.raw: got %0d expected %0d", d, ec); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL b2b.done: got %0b expected 1", dn); end
  endtask

  task automatic test_reset_mid();
    int acc, st, a, d, s, c, ec, ek;
    bit got, dn;
    clear_tab();
    for (int x = 0; x < 4; x++) set_dim(x, 2 + x);
    preload(0, 1, 1000);
    preload(1, 2, 0);
    set_matlen(3);
    drive(0, 2, 0, 1'b0, acc, st);      // cheap candidate lands in the running min
    idle(1);
    drive(0, 2, 1, 1'b1, acc, st);
    @(negedge clk); idx_valid = 1'b0;   // T+1
    @(negedge clk); rst = 1'b1;         // T+2
    @(negedge clk); rst = 1'b0;         // T+3
    checks++; if (cost_we !== 1'b0) begin errors++; $display("FAIL rstmid.cost_we: got %0b expected 0", cost_we); end
    checks++; if (idx_ready !== 1'b1) begin errors++; $display("FAIL rstmid.idx_ready: got %0b expected 1", idx_ready); end
    idle(4);
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL rstmid.suppress: got %0d writes expected 0", wq_addr.size()); end
    wq_addr.delete(); wq_data.delete(); wq_split.delete(); wq_cyc.delete(); wq_done.delete();
    drive(0, 2, 1, 1'b1, acc, st);
    idle(1);
    wait_write(got, a, d, s, c, dn);
    mgroup(0, 2, 1, 1, ec, ek);
    checks++; if (!got || d !== ec) begin errors++; $display("FAIL rstmid.wdata: got %0d expected %0d", d, ec); end
    checks++; if (s !== ek) begin errors++; $display("FAIL rstmid.split: got %0d expected %0d", s, ek); end
  endtask

  task automatic test_random();
    int acc, st, a, d, s, c, ec, ek, n, j;
    bit got, dn;
    for (int run = 0; run < 4; run++) begin
      n = $urandom_range(2, 8);
      clear_tab();
      for (int x = 0; x <= n; x++) set_dim(x, (run == 3) ? $urandom_range(1, 255) : $urandom_range(1, 40));
      set_matlen(n);
      for (int len = 2; len <= n; len++) begin
        for (int i = 0; i <= n - len; i++) begin
          j = i + len - 1;
          for (int k = i; k < j; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            drive(i, j, k, k == j - 1, acc, st);
          end
          idle(1);
          wait_write(got, a, d, s, c, dn);
          mgroup(i, j, i, j - 1, ec, ek);
          mm[i][j] = ec;
          checks++; if (!got || a !== (i << 8 | j)) begin errors++; $display("FAIL rand.waddr: got %h expected %h", a, i << 8 | j); end
          checks++; if (d !== ec) begin errors++; $display("FAIL rand.wdata m[%0d][%0d]: got %0d expected %0d", i, j, d, ec); end
          checks++; if (s !== ek) begin errors++; $display("FAIL rand.split s[%0d][%0d]: got %0d expected %0d", i, j, s, ek); end
          checks++; if (dn !== (i == 0 && j == n - 1)) begin errors++; $display("FAIL rand.done (%0d,%0d): got %0b", i, j, dn); end
          checks++; if (c !== acc + 3) begin errors++; $display("FAIL rand.latency: write cycle %0d expected %0d", c, acc + 3); end
        end
      end
    end
    checks++; if (stray_done !== 0) begin errors++; $display("FAIL rand.stray_done: got %0d expected 0", stray_done); end
  endtask

  initial begin
    test_reset();
    test_groups();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
